// File: rtl/input_buffer_if.sv
// Flit link into the input buffer and the flit/enable pair it hands to route computation.
interface input_buffer_if;
    logic [31:0] flit_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] flit_out;
    logic        enable;
    logic        out_ack;

    // Upstream link and route-computation side, as seen from outside the buffer.
    modport master (
        output flit_in,
        output in_valid,
        output out_ack,
        input  in_ready,
        input  flit_out,
        input  enable
    );

    // The buffer itself.
    modport slave (
        input  flit_in,
        input  in_valid,
        input  out_ack,
        output in_ready,
        output flit_out,
        output enable
    );
endinterface

// File: rtl/input_buffer.sv
// Per-port input FIFO for the mesh router. Buffers link flits, presents one at a
// time to route computation, tracks packet framing and drops orphan body/tail flits.
//
// state | meaning
// IDLE  | between packets; expecting head or single
// PKT   | inside a packet; expecting body or tail
module input_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input_buffer_if.slave bus,
    output logic [AW:0]   count,
    output logic          err_frame
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic {IDLE, PKT} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [31:0]   flit_out_q;
    logic          enable_q;
    logic          full;
    logic          empty;
    logic          do_write;
    logic          do_pop;
    logic [1:0]    pop_type;

    // Full/empty come from the occupancy count; the pointers alone are ambiguous.
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_write = bus.in_valid && !full;
    assign do_pop   = !empty && (!enable_q || bus.out_ack);
    assign pop_type = mem[rptr][31:30];

    assign bus.in_ready = !full;
    assign bus.flit_out = flit_out_q;
    assign bus.enable   = enable_q;

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr] <= bus.flit_in;
        end
    end

    // Write/read pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_write) wptr <= wptr + PTR_ONE;
            if (do_pop)   rptr <= rptr + PTR_ONE;
            case ({do_write, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Framing FSM with the registered output stage and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flit_out_q <= '0;
            enable_q   <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (do_pop) begin
                flit_out_q <= mem[rptr];
                enable_q   <= 1'b1;
                case (state)
                    IDLE: begin
                        case (pop_type)
                            T_HEAD:   state <= PKT;
                            T_SINGLE: state <= IDLE;
                            default: begin
                                // Orphan body/tail: entry is consumed but never presented.
                                enable_q  <= 1'b0;
                                err_frame <= 1'b1;
                            end
                        endcase
                    end
                    PKT: begin
                        case (pop_type)
                            T_BODY: state <= PKT;
                            T_TAIL: state <= IDLE;
                            T_HEAD: begin
                                err_frame <= 1'b1;
                                state     <= PKT;
                            end
                            default: begin
                                err_frame <= 1'b1;
                                state     <= IDLE;
                            end
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end else if (enable_q && bus.out_ack) begin
                enable_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: per-cycle vector table plus hand sequences
// for fill-to-full, pointer wrap and reset in the middle of a packet.
module tb_input_buffer;

    logic       clk;
    logic       rst;
    logic [2:0] count;
    logic       err_frame;

    int n_cmp;
    int n_bad;

    input_buffer_if bus ();

    input_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .count     (count),
        .err_frame (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [31:0] flit_in;
        logic        out_ack;
        logic        exp_en;
        logic [31:0] exp_fo;
        logic [2:0]  exp_cnt;
        logic        exp_rdy;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [31:0] f, input logic a);
        rst          = r;
        bus.in_valid = v;
        bus.flit_in  = f;
        bus.out_ack  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [31:0] fo,
                           input logic [2:0] cnt, input logic rdy, input logic err);
        chk({tag, " enable"},    32'(bus.enable),   32'(en));
        chk({tag, " flit_out"},  bus.flit_out,      fo);
        chk({tag, " count"},     32'(count),        32'(cnt));
        chk({tag, " in_ready"},  32'(bus.in_ready), 32'(rdy));
        chk({tag, " err_frame"}, 32'(err_frame),    32'(err));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // rst, valid, flit, ack | en, flit_out, count, ready, err
        // reset held 2 cycles with in_valid high: nothing written
        vq.push_back('{1'b1, 1'b1, 32'hC0000012, 1'b0, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 1'b1, 32'hC0000012, 1'b0, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b0});
        // single flit, ack high: enable one edge after the write edge
        vq.push_back('{1'b0, 1'b1, 32'hC0000012, 1'b1, 1'b0, 32'h00000000, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'hC0000012, 3'd0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hC0000012, 3'd0, 1'b1, 1'b0});
        // head/body/tail with ack low: head held, two queued
        vq.push_back('{1'b0, 1'b1, 32'h40000105, 1'b0, 1'b0, 32'hC0000012, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h000000AA, 1'b0, 1'b1, 32'h40000105, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h800000BB, 1'b0, 1'b1, 32'h40000105, 3'd2, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h40000105, 3'd2, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h000000AA, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h800000BB, 3'd0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h800000BB, 3'd0, 1'b1, 1'b0});
        // orphan body in IDLE: dropped, error pulse for one cycle
        vq.push_back('{1'b0, 1'b1, 32'h00000033, 1'b0, 1'b0, 32'h800000BB, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000033, 3'd0, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000033, 3'd0, 1'b1, 1'b0});
        // single in IDLE is clean; ack while enable low is ignored
        vq.push_back('{1'b0, 1'b1, 32'hC0000077, 1'b1, 1'b0, 32'h00000033, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'hC0000077, 3'd0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hC0000077, 3'd0, 1'b1, 1'b0});
        // head, head, single: second head and the single both flag but are forwarded
        vq.push_back('{1'b0, 1'b1, 32'h40000001, 1'b1, 1'b0, 32'hC0000077, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h40000002, 1'b1, 1'b1, 32'h40000001, 3'd1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'hC0000003, 1'b1, 1'b1, 32'h40000002, 3'd1, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'hC0000003, 3'd0, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hC0000003, 3'd0, 1'b1, 1'b0});

        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].in_valid, vq[i].flit_in, vq[i].out_ack);
            chk_all($sformatf("vec%0d", i), vq[i].exp_en, vq[i].exp_fo,
                    vq[i].exp_cnt, vq[i].exp_rdy, vq[i].exp_err);
        end

        // Fill: one flit in the output register, four more fill the FIFO.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'hC00000A0 + 32'(i), 1'b0);
        chk_all("full", 1'b1, 32'hC00000A0, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 32'hC00000A5, 1'b0);
            chk_all($sformatf("full_hold%0d", i), 1'b1, 32'hC00000A0, 3'd4, 1'b0, 1'b0);
        end
        // pop with the extra flit still offered: no write-through while full
        cyc(1'b0, 1'b1, 32'hC00000A5, 1'b1);
        chk_all("full_ack", 1'b1, 32'hC00000A1, 3'd3, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'hC00000A5, 1'b0);
        chk_all("full_refill", 1'b1, 32'hC00000A1, 3'd4, 1'b0, 1'b0);
        for (int i = 2; i < 6; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            chk_all($sformatf("drain%0d", i), 1'b1, 32'hC00000A0 + 32'(i), 3'(5 - i), 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("drain_end", 1'b0, 32'hC00000A5, 3'd0, 1'b1, 1'b0);

        // Stream 10 singles at full rate; order must survive the pointer wrap.
        for (int k = 0; k < 11; k++) begin
            cyc(1'b0, (k < 10) ? 1'b1 : 1'b0, 32'hC0000100 + 32'(k), 1'b1);
            if (k >= 1) begin
                chk($sformatf("stream%0d enable", k), 32'(bus.enable), 32'd1);
                chk($sformatf("stream%0d flit_out", k), bus.flit_out, 32'hC0000100 + 32'(k - 1));
            end
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("stream_end", 1'b0, 32'hC0000109, 3'd0, 1'b1, 1'b0);

        // Reset inside a packet: the next body is an orphan.
        cyc(1'b0, 1'b1, 32'h40000200, 1'b1);
        chk_all("mid_head", 1'b0, 32'hC0000109, 3'd1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h00000201, 1'b1);
        chk_all("mid_body", 1'b1, 32'h40000200, 3'd1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk_all("mid_rst", 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h00000202, 1'b1);
        chk_all("post_rst_wr", 1'b0, 32'h00000000, 3'd1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("post_rst_drop", 1'b0, 32'h00000202, 3'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("post_rst_idle", 1'b0, 32'h00000202, 3'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
